// File: rtl/spio_status_led_multimode.sv
// Multi-mode status LEDs: lamp test, blink-coded errors, activity blink,
// idle throb and a power-on pulse, scaled by a global PWM brightness.
module spio_status_led_multimode #(
   parameter int NUM_DEVICES           = 4,
   parameter int PWM_BITS              = 8,
   parameter int ANIMATION_PERIOD_BITS = 27,
   parameter int PULSE_DURATION        = 7500000,
   parameter int ACTIVITY_BLINK_BIT    = 23,
   parameter int ACTIVITY_TIMEOUT      = 37500000,
   parameter int ACTIVITY_TIMEOUT_BITS = 26,
   parameter int CODE_BITS             = 3,
   parameter int CODE_UNIT_BITS        = 22
) (
   input  logic                           CLK_IN,
   input  logic                           RESET_N_IN,
   input  logic [NUM_DEVICES-1:0]           ERROR_IN,
   input  logic [NUM_DEVICES*CODE_BITS-1:0] ERROR_CODE_IN,
   input  logic [NUM_DEVICES-1:0]           CONNECTED_IN,
   input  logic [NUM_DEVICES-1:0]           ACTIVITY_IN,
   input  logic [PWM_BITS-1:0]              BRIGHTNESS_IN,
   input  logic                           LAMP_TEST_IN,
   output logic [NUM_DEVICES-1:0]           LED_OUT,
   output logic                           ANIMATION_REPEAT_OUT
);
   localparam int DW = PWM_BITS + 1;
   localparam int UW = CODE_UNIT_BITS + 2;
   localparam int PW = 2 * DW;
   localparam int APB = ANIMATION_PERIOD_BITS;
   localparam logic [DW-1:0] FULL = DW'(1) << PWM_BITS;
   // GAP ends one cycle early: the IDLE cycle completes the 4-unit gap
   localparam logic [UW-1:0] GAP_LAST = UW'((4 << CODE_UNIT_BITS) - 2);
   localparam logic [ACTIVITY_TIMEOUT_BITS-1:0] ACT_LOAD =
      ACTIVITY_TIMEOUT_BITS'(ACTIVITY_TIMEOUT);

   typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_e;

   logic [PWM_BITS-1:0] pwm_q;
   logic [APB-1:0]      period_q;
   logic                repeat_q;
   logic                lamp_q;
   logic [PWM_BITS-1:0] ramp;
   logic [DW-1:0]       pulse_lvl;
   logic [DW-1:0]       blink_lvl;
   logic [DW-1:0]       throb_lvl;
   logic [DW-1:0]       bright1;

   always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
      if (!RESET_N_IN) begin
         pwm_q    <= '0;
         period_q <= '0;
         repeat_q <= 1'b0;
         lamp_q   <= 1'b0;
      end else begin
         pwm_q    <= pwm_q + 1'b1;
         period_q <= period_q + 1'b1;
         repeat_q <= &period_q;
         lamp_q   <= LAMP_TEST_IN;
      end
   end

   assign ANIMATION_REPEAT_OUT = repeat_q;
   assign ramp = period_q[APB-2 -: PWM_BITS];

   always_comb begin
      pulse_lvl = (32'(period_q) < PULSE_DURATION) ? FULL : '0;
      blink_lvl = period_q[ACTIVITY_BLINK_BIT] ? FULL : '0;
      throb_lvl = {1'b0, period_q[APB-1] ? ~ramp : ramp};
      bright1   = {1'b0, BRIGHTNESS_IN} + DW'(1);
   end

   for (genvar i = 0; i < NUM_DEVICES; i++) begin : g_dev
      state_e                     state_q, state_d;
      logic [UW-1:0]              unit_q, unit_d;
      logic [CODE_BITS-1:0]       code_q, code_d;
      logic [CODE_BITS-1:0]       cnt_q, cnt_d;
      logic [ACTIVITY_TIMEOUT_BITS-1:0] act_q, act_d;
      logic [DW-1:0]              level_q, level_d;
      logic [DW-1:0]              duty_q, duty_d;
      logic [PW-1:0]              prod;
      logic                       led_q, led_d;
      logic                       unit_end;

      assign unit_end = &unit_q[CODE_UNIT_BITS-1:0];

      always_comb begin
         state_d = state_q;
         unit_d  = unit_q + 1'b1;
         code_d  = code_q;
         cnt_d   = cnt_q;
         unique case (state_q)
            IDLE: begin
               unit_d = '0;
               cnt_d  = '0;
               if (ERROR_IN[i]) begin
                  state_d = ON;
                  code_d  = ERROR_CODE_IN[i*CODE_BITS +: CODE_BITS];
               end
            end
            ON: begin
               if (unit_end) begin
                  state_d = OFF;
                  unit_d  = '0;
               end
            end
            OFF: begin
               if (unit_end) begin
                  unit_d = '0;
                  if (cnt_q == code_q) begin
                     state_d = GAP;
                  end else begin
                     cnt_d   = cnt_q + 1'b1;
                     state_d = ON;
                  end
               end
            end
            GAP: begin
               if (unit_q == GAP_LAST) begin
                  state_d = IDLE;
                  unit_d  = '0;
               end
            end
            default: state_d = IDLE;
         endcase
         if (!ERROR_IN[i]) begin
            state_d = IDLE;
            unit_d  = '0;
            cnt_d   = '0;
         end
      end

      always_comb begin
         act_d = act_q;
         if (ACTIVITY_IN[i]) begin
            act_d = ACT_LOAD;
         end else if (act_q != '0) begin
            act_d = act_q - 1'b1;
         end
         level_d = pulse_lvl;
         if (LAMP_TEST_IN) begin
            level_d = FULL;
         end else if (ERROR_IN[i]) begin
            level_d = (state_q == ON) ? FULL : '0;
         end else if (CONNECTED_IN[i]) begin
            level_d = (act_q != '0) ? blink_lvl : throb_lvl;
         end
         prod   = PW'(level_q) * PW'(bright1);
         duty_d = lamp_q ? FULL : DW'(prod >> PWM_BITS);
         led_d  = {1'b0, pwm_q} < duty_q;
      end

      always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
         if (!RESET_N_IN) begin
            state_q <= IDLE;
            unit_q  <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
            act_q   <= '0;
            level_q <= '0;
            duty_q  <= '0;
            led_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            unit_q  <= unit_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            level_q <= level_d;
            duty_q  <= duty_d;
            led_q   <= led_d;
         end
      end

      assign LED_OUT[i] = led_q;
   end

endmodule

// File: tb/tb_spio_status_led_multimode.sv
// Scoreboard bench for spio_status_led_multimode: expected LED samples are
// queued when stimulus is applied and compared on each falling edge.
module tb_spio_status_led_multimode;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] err;
   logic [5:0] code;
   logic [1:0] conn;
   logic [1:0] act;
   logic [3:0] br;
   logic       lamp;
   logic [1:0] led;
   logic       rep;

   typedef struct {
      string      tag;
      logic [1:0] mask;
      logic [1:0] exp;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   k, c, m, p, lvl;

   spio_status_led_multimode #(
      .NUM_DEVICES(2),
      .PWM_BITS(4),
      .ANIMATION_PERIOD_BITS(10),
      .PULSE_DURATION(100),
      .ACTIVITY_BLINK_BIT(2),
      .ACTIVITY_TIMEOUT(5),
      .ACTIVITY_TIMEOUT_BITS(3),
      .CODE_BITS(3),
      .CODE_UNIT_BITS(3)
   ) dut (
      .CLK_IN(clk),
      .RESET_N_IN(rst_n),
      .ERROR_IN(err),
      .ERROR_CODE_IN(code),
      .CONNECTED_IN(conn),
      .ACTIVITY_IN(act),
      .BRIGHTNESS_IN(br),
      .LAMP_TEST_IN(lamp),
      .LED_OUT(led),
      .ANIMATION_REPEAT_OUT(rep)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t",
                    tag, got, exp, $time);
   endtask

   task automatic push(input string tag, input logic [1:0] mask,
                       input logic [1:0] exp);
      exp_t x;
      x.tag  = tag;
      x.mask = mask;
      x.exp  = exp;
      sb.push_back(x);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      check("drain", sb.size(), 0);
      #1;
   endtask

   // pulses of 8 on / 8 off, c+1 of them, then 32 dark; first on at j=4
   function automatic bit code_led(input int j, input int cc);
      int t;
      if (j < 4) return 1'b0;
      t = (j - 4) % (16 * (cc + 1) + 32);
      return (t < 16 * (cc + 1)) && ((t % 16) < 8);
   endfunction

   function automatic int throb_lvl(input int pp);
      int r;
      r = (pp >> 5) & 15;
      return ((pp >> 9) & 1) != 0 ? 15 - r : r;
   endfunction

   function automatic int blink_lvl(input int pp);
      return ((pp >> 2) & 1) != 0 ? 16 : 0;
   endfunction

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.mask != 2'b00)
            check(e.tag, 32'(led & e.mask), 32'(e.exp & e.mask));
      end
      check("repeat", 32'(rep),
            32'((cyc != 0) && (cyc % 1024 == 0)));
   end

   initial begin
      rst_n = 1'b1;
      lamp  = 1'b1;
      br    = 4'd0;
      err   = 2'b00;
      code  = 6'd0;
      conn  = 2'b00;
      act   = 2'b00;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_led", 32'(led), 0);
      check("rst_rep", 32'(rep), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int j = 0; j < 3; j++) push("lamp_pre", 2'b11, 2'b00);
      for (int j = 3; j <= 40; j++) push("lamp", 2'b11, 2'b11);
      drain();
      #1 check("lamp_hold", 32'(led), 32'd3);
      #1 rst_n = 1'b0;
      #1 check("rst_async", 32'(led), 0);
      lamp = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) step();

      err  = 2'b01;
      code = 6'o02;
      br   = 4'd15;
      for (int j = 0; j < 3; j++) push("skip", 2'b00, 2'b00);
      for (int j = 3; j <= 163; j++)
         push("err_code2", 2'b01, {1'b0, code_led(j, 2)});
      drain();
      err = 2'b00;
      repeat (4) step();

      k    = cyc;
      err  = 2'b01;
      code = 6'o00;
      br   = 4'd7;
      for (int j = 0; j < 3; j++) push("skip", 2'b00, 2'b00);
      for (int j = 3; j <= 99; j++)
         push("err_br7", 2'b01,
              {1'b0, code_led(j, 0) && (((k + j - 1) % 16) < 8)});
      drain();
      err  = 2'b00;
      br   = 4'd15;
      conn = 2'b10;
      repeat (5) step();

      k   = cyc;
      act = 2'b10;
      for (int j = 0; j < 3; j++) push("skip", 2'b00, 2'b00);
      for (int j = 3; j <= 40; j++) begin
         c = k + j;
         m = c - 2;
         p = (m - 1) % 1024;
         if (m >= k + 2 && m <= k + 6) lvl = blink_lvl(p);
         else lvl = throb_lvl(p);
         push("act_blink", 2'b10, {((c - 1) % 16) < lvl, 1'b0});
      end
      step();
      act = 2'b00;
      drain();
      conn = 2'b00;
      repeat (3) step();

      err  = 2'b11;
      code = 6'o71;
      for (int j = 0; j < 3; j++) push("skip", 2'b00, 2'b00);
      for (int j = 3; j <= 55; j++)
         push("err_pre", 2'b11, {code_led(j, 7), code_led(j, 1)});
      drain();
      #1 check("pre_rst", 32'(led), 32'd2);
      #1 rst_n = 1'b0;
      #1 check("rst_gap", 32'(led), 0);
      check("rst_gap_rep", 32'(rep), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int j = 0; j <= 50; j++)
         push("restart", 2'b11, {code_led(j, 7), code_led(j, 1)});
      drain();
      err = 2'b00;
      repeat (2200) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
